// File: rtl/neuron_mac_if.sv
// Handshake and operand bundle between a layer controller and one neuron_mac_engine.
interface neuron_mac_if #(
    parameter int N  = 10,
    parameter int DW = 8
);
    logic            start;
    logic [DW*N-1:0] inp;
    logic [DW*N-1:0] w;
    logic [DW-1:0]   bias;
    logic            hidden;
    logic            relu;
    logic            ready;
    logic            done;
    logic [DW-1:0]   result;
    logic            ovf;

    modport master (
        output start, inp, w, bias, hidden, relu,
        input  ready, done, result, ovf
    );

    modport slave (
        input  start, inp, w, bias, hidden, relu,
        output ready, done, result, ovf
    );
endinterface

// File: rtl/neuron_mac_engine.sv
// Multi-lane sequential neuron: saturating dot product, scaled bias, optional shift,
// ReLU or linear-saturate activation, with start/ready/done handshake.
module neuron_mac_engine #(
    parameter int N          = 10,
    parameter int DW         = 8,
    parameter int ACC_W      = 21,
    parameter int LANES      = 1,
    parameter int SHIFT      = 9,
    parameter int BIAS_SCALE = 127
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  io
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_ACT  = 2'd3
    } state_t;

    localparam int IDX_W = $clog2(N + LANES) + 1;
    // Headroom so accumulator + full lane sum (or scaled bias) never wraps before clamping.
    localparam int EXT_W = ACC_W + 2 * DW + $clog2(LANES + 1) + 2;

    localparam logic signed [EXT_W-1:0] ACC_MAX_EXT = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN_EXT = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] BIAS_SCALE_EXT = EXT_W'(BIAS_SCALE);
    localparam logic signed [ACC_W-1:0] RES_MAX_ACC = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN_ACC = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] RES_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] RES_MIN = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] x);
        if (x > ACC_MAX_EXT) begin
            return ACC_MAX_EXT[ACC_W-1:0];
        end else if (x < ACC_MIN_EXT) begin
            return ACC_MIN_EXT[ACC_W-1:0];
        end else begin
            return x[ACC_W-1:0];
        end
    endfunction

    function automatic logic sat_hit(input logic signed [EXT_W-1:0] x);
        return (x > ACC_MAX_EXT) || (x < ACC_MIN_EXT);
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_int_q, ovf_int_d;
    logic [DW*N-1:0]         inp_q, inp_d;
    logic [DW*N-1:0]         w_q, w_d;
    logic [DW-1:0]           bias_q, bias_d;
    logic                    hidden_q, hidden_d;
    logic                    relu_q, relu_d;
    logic [DW-1:0]           result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;

    logic signed [EXT_W-1:0] lane_sum_s;
    logic signed [EXT_W-1:0] acc_ext_s;
    logic signed [EXT_W-1:0] mac_sum_s;
    logic signed [EXT_W-1:0] bias_sum_s;
    logic signed [ACC_W-1:0] v_s;
    logic [DW-1:0]           act_s;

    // Lane sum: each lane muxes its operand pair by index; out-of-range lanes add zero.
    always_comb begin
        logic signed [DW-1:0]   a_s;
        logic signed [DW-1:0]   b_s;
        logic signed [2*DW-1:0] prod_s;
        int                     j_s;
        lane_sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            j_s = int'(idx_q) + l;
            a_s = '0;
            b_s = '0;
            for (int k = 0; k < N; k++) begin
                if (k == j_s) begin
                    a_s = inp_q[DW*k +: DW];
                    b_s = w_q[DW*k +: DW];
                end else begin
                    a_s = a_s;
                    b_s = b_s;
                end
            end
            prod_s = a_s * b_s;
            lane_sum_s = lane_sum_s + {{(EXT_W-2*DW){prod_s[2*DW-1]}}, prod_s};
        end
    end

    // Wide sums ahead of saturation, and the activation of the current accumulator.
    always_comb begin
        acc_ext_s  = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        mac_sum_s  = acc_ext_s + lane_sum_s;
        bias_sum_s = acc_ext_s + ({{(EXT_W-DW){bias_q[DW-1]}}, bias_q} * BIAS_SCALE_EXT);
        v_s        = hidden_q ? (acc_q >>> SHIFT) : acc_q;
        if (relu_q) begin
            if (v_s[ACC_W-1]) begin
                act_s = '0;
            end else if (v_s > RES_MAX_ACC) begin
                act_s = RES_MAX;
            end else begin
                act_s = v_s[DW-1:0];
            end
        end else begin
            if (v_s > RES_MAX_ACC) begin
                act_s = RES_MAX;
            end else if (v_s < RES_MIN_ACC) begin
                act_s = RES_MIN;
            end else begin
                act_s = v_s[DW-1:0];
            end
        end
    end

    // Next-state and datapath update for IDLE -> MAC -> BIAS -> ACT.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        ovf_int_d = ovf_int_q;
        inp_d     = inp_q;
        w_d       = w_q;
        bias_d    = bias_q;
        hidden_d  = hidden_q;
        relu_d    = relu_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    inp_d     = io.inp;
                    w_d       = io.w;
                    bias_d    = io.bias;
                    hidden_d  = io.hidden;
                    relu_d    = io.relu;
                    acc_d     = '0;
                    ovf_int_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d     = sat_acc(mac_sum_s);
                ovf_int_d = ovf_int_q | sat_hit(mac_sum_s);
                idx_d     = idx_q + IDX_W'(LANES);
                if (int'(idx_q) + LANES >= N) begin
                    state_d = ST_BIAS;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_BIAS: begin
                acc_d     = sat_acc(bias_sum_s);
                ovf_int_d = ovf_int_q | sat_hit(bias_sum_s);
                state_d   = ST_ACT;
            end
            ST_ACT: begin
                result_d = act_s;
                ovf_d    = ovf_int_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            ovf_int_q <= 1'b0;
            inp_q     <= '0;
            w_q       <= '0;
            bias_q    <= '0;
            hidden_q  <= 1'b0;
            relu_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            ovf_int_q <= ovf_int_d;
            inp_q     <= inp_d;
            w_q       <= w_d;
            bias_q    <= bias_d;
            hidden_q  <= hidden_d;
            relu_q    <= relu_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign io.ready  = (state_q == ST_IDLE);
    assign io.done   = done_q;
    assign io.result = result_q;
    assign io.ovf    = ovf_q;

endmodule

// File: doc/neuron_mac_engine.md
Name: neuron_mac_engine

Overview:
Sequential, parametrised neuron. It computes one dot product of N signed inputs and N signed weights, LANES multiply-accumulates per clock, into a saturating accumulator. It then adds a scaled bias, optionally applies the hidden-layer shift, and produces a DW-bit activated result. It is the successor to the single-lane neuron datapath, adding a start/ready/done handshake, lane parallelism, saturation, overflow reporting and selectable activation. Layer controllers instantiate one per neuron.

Parameters:
N, 10, number of input/weight pairs per neuron (>=1)
DW, 8, element width; inputs, weights, bias and result are signed two's complement
ACC_W, 21, accumulator width (>= 2*DW)
LANES, 1, products accumulated per clock (1..N)
SHIFT, 9, arithmetic right-shift applied when hidden=1
BIAS_SCALE, 127, constant multiplier for bias before accumulation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when ready=1
inp  in  DW*N  input vector; element i = inp[DW*i +: DW]
w  in  DW*N  weight vector, same packing
bias  in  DW  signed bias
hidden  in  1  1 = apply >>>SHIFT before activation
relu  in  1  1 = ReLU activation, 0 = linear saturate
ready  out  1  high in IDLE
done  out  1  one-cycle pulse when result/ovf update
result  out  DW  activated output, held until next done
ovf  out  1  accumulator saturated during the last operation, held with result

Behaviour:
- Reset (async, rst=1): state=IDLE; ready=1; done=0; result=0; ovf=0; accumulator and index=0. Assertion mid-operation aborts the operation; no done pulse follows.
- States: IDLE -> MAC -> BIAS -> ACT -> IDLE.
- IDLE: when start=1 at edge E0, latch inp, w, bias, hidden, relu; clear the accumulator and sticky overflow; set idx=0; go to MAC. start while not ready is ignored. Operands may change after E0.
- MAC: each edge adds the sum of products idx..idx+LANES-1 to the accumulator. Indices >= N contribute 0. Products are DW x DW signed, giving 2*DW bits, sign-extended. The lane sum is formed at full width and added once, saturating to the ACC_W signed range. Any clamp sets sticky ovf_int. idx += LANES. After M = ceil(N/LANES) edges, go to BIAS.
- BIAS: acc = sat(acc + bias*BIAS_SCALE), which also updates ovf_int. Go to ACT.
- ACT: v = hidden ? acc>>>SHIFT (floor) : acc. Activation:
  - relu=1: v<0 -> 0; v>2^(DW-1)-1 -> 2^(DW-1)-1.
  - relu=0: clamp to [-2^(DW-1), 2^(DW-1)-1].
  - Register result and ovf=ovf_int, pulse done=1, go to IDLE.
- Latency: done is high in the cycle after edge E(M+2); ready returns in that same cycle. The next start can be sampled at E(M+3), so back-to-back throughput is one result per M+3 cycles.
- Results come from the latched operands only. result and ovf do not change except at a done or at reset.

Test Plan:
1. Reset with defaults -> ready=1, done=0, result=0, ovf=0. Reset asserted during MAC -> ready=1 immediately; no done pulse in the next 20 cycles.
2. Defaults; inp all 3, w all 2, bias=0, hidden=0, relu=0; start -> done exactly 12 cycles after the start edge, result=60, ovf=0. start pulses during busy -> ignored, single done.
3. inp all 127, w all 127, hidden=1, relu=0 -> acc=161290; >>>9 gives 315; result=127, ovf=0. Same with hidden=0 -> result=127.
4. inp all -128, w all 127 (acc=-162560): relu=1 -> result=0; relu=0, hidden=1 -> -318 clamped to result=-128.
5. inp and w all 0: bias=1 -> result=127; bias=-1 -> result=-127. With hidden=1 and bias=1 -> 127>>>9=0, result=0.
6. LANES=4, ACC_W=16 instance; inp and w all 127 -> done 5 cycles after start; acc saturates at 32767, ovf=1, result=127. A following run with all-zero operands -> ovf=0, result=0.
